// File: rtl/ibex_ccu_bridge.sv
// Bridges the EX-stage CCU command (level-held en_i) to a CFU with valid/ready
// command and response channels; each EX instruction reaches the CFU at most once.
module ibex_ccu_bridge #(
    parameter int unsigned TimeoutCycles = 255
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        en_i,
    input  logic [9:0]  function_id_i,
    input  logic [31:0] inputs_0_i,
    input  logic [31:0] inputs_1_i,
    input  logic        id_ready_i,
    output logic        rsp_valid_o,
    output logic [31:0] rsp_result_o,
    output logic        err_o,
    output logic        cfu_cmd_valid_o,
    input  logic        cfu_cmd_ready_i,
    output logic [9:0]  cfu_cmd_function_id_o,
    output logic [31:0] cfu_cmd_inputs_0_o,
    output logic [31:0] cfu_cmd_inputs_1_o,
    input  logic        cfu_rsp_valid_i,
    output logic        cfu_rsp_ready_o,
    input  logic [31:0] cfu_rsp_outputs_0_i
);

    // Handshake rule on both CFU channels: a transfer happens on a rising clock
    // edge where valid and ready are both high; valid never depends on ready.

    localparam int unsigned CntW = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'((TimeoutCycles > 0) ? TimeoutCycles - 1 : 0);
    localparam logic [CntW-1:0] CntMax  = {CntW{1'b1}};

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WAIT_RSP,
        ST_DONE,
        ST_DRAIN
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] cnt_q, cnt_d, cnt_inc;
    logic            owed_q, owed_d;
    logic [9:0]      fid_q, fid_d;
    logic [31:0]     op0_q, op0_d;
    logic [31:0]     op1_q, op1_d;
    logic [31:0]     result_q, result_d;
    logic            err_q, err_d;
    logic            timeout_hit;

    assign cnt_inc     = (cnt_q == CntMax) ? cnt_q : cnt_q + 1'b1;
    // The counter value during the N-th waiting cycle is N-1, so the timeout
    // fires after exactly TimeoutCycles cycles of waiting.
    assign timeout_hit = (TimeoutCycles != 0) && (cnt_q == CntLast);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= ST_IDLE;
            cnt_q    <= '0;
            owed_q   <= 1'b0;
            fid_q    <= '0;
            op0_q    <= '0;
            op1_q    <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            owed_q   <= owed_d;
            fid_q    <= fid_d;
            op0_q    <= op0_d;
            op1_q    <= op1_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        owed_d   = owed_q;
        fid_d    = fid_q;
        op0_d    = op0_q;
        op1_d    = op1_q;
        result_d = result_q;
        err_d    = err_q;

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (en_i) begin
                    fid_d   = function_id_i;
                    op0_d   = inputs_0_i;
                    op1_d   = inputs_1_i;
                    state_d = ST_CMD;
                end
            end

            ST_CMD: begin
                // Once the CFU has accepted the command it owes a response,
                // so the handshake outranks a simultaneous kill.
                if (cfu_cmd_ready_i) begin
                    cnt_d   = '0;
                    state_d = ST_WAIT_RSP;
                end else if (!en_i) begin
                    state_d = ST_IDLE;
                end
            end

            ST_WAIT_RSP: begin
                cnt_d = cnt_inc;
                if (cfu_rsp_valid_i) begin
                    if (en_i) begin
                        result_d = cfu_rsp_outputs_0_i;
                        err_d    = 1'b0;
                        owed_d   = 1'b0;
                        state_d  = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (!en_i) begin
                    cnt_d   = '0;
                    state_d = ST_DRAIN;
                end else if (timeout_hit) begin
                    result_d = '0;
                    err_d    = 1'b1;
                    owed_d   = 1'b1;
                    state_d  = ST_DONE;
                end
            end

            ST_DONE: begin
                if (id_ready_i || !en_i) begin
                    cnt_d   = '0;
                    owed_d  = 1'b0;
                    state_d = owed_q ? ST_DRAIN : ST_IDLE;
                end
            end

            ST_DRAIN: begin
                cnt_d = cnt_inc;
                if (cfu_rsp_valid_i || timeout_hit) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Every output is a flop or a decode of the state register only.
    assign cfu_cmd_valid_o       = (state_q == ST_CMD);
    assign cfu_rsp_ready_o       = (state_q == ST_WAIT_RSP) || (state_q == ST_DRAIN);
    assign rsp_valid_o           = (state_q == ST_DONE);
    assign rsp_result_o          = result_q;
    assign err_o                 = err_q;
    assign cfu_cmd_function_id_o = fid_q;
    assign cfu_cmd_inputs_0_o    = op0_q;
    assign cfu_cmd_inputs_1_o    = op1_q;

endmodule
